// File: rtl/pa_pkg.sv
// Shared register-file parameters and write-back request type for the
// write-back controller slice.
package pa_pkg;

  localparam int unsigned REG_SIZE_DEF = 32;
  localparam int unsigned MEM_SIZE_DEF = 32;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ADDR_W_DEF = addr_w(MEM_SIZE_DEF);

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]   addr;
    logic [REG_SIZE_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from an internal
// pointer, which moves past the winner whenever advance is asserted.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;

  // Winner is the requester with the smallest wrap-around distance from ptr.
  always_comb begin
    int unsigned best;
    int unsigned d;
    best    = N;
    d       = 0;
    gnt_idx = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (req[j]) begin
        d = (j + N - 32'(ptr)) % N;
        if (d < best) begin
          best    = d;
          gnt_idx = PW'(j);
        end
      end
    end
    gnt_any = (best < N);
    gnt     = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && gnt_any) begin
      ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: arbitrates the single write port,
// drives Din/WE from a registered stage and tracks pending writes.
module regfile_wb_ctrl
  import pa_pkg::*;
#(
  parameter  int unsigned reg_size = REG_SIZE_DEF,
  parameter  int unsigned mem_size = MEM_SIZE_DEF,
  parameter  int unsigned N_REQ    = 2,
  parameter  bit          ZERO_RO  = 1'b1,
  localparam int unsigned ADDR_W   = addr_w(mem_size)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][ADDR_W-1:0]     req_addr,
  input  logic [N_REQ-1:0][reg_size-1:0]   req_data,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [reg_size-1:0]              rf_din,
  output logic [mem_size-1:0]              rf_we,
  input  logic                             rsv_valid,
  input  logic [ADDR_W-1:0]                rsv_addr,
  output logic                             rsv_ready,
  output logic [mem_size-1:0]              busy
);

  logic                hs;
  logic [ADDR_W-1:0]   sel_addr;
  logic [reg_size-1:0] sel_data;
  logic                wr_zero;
  logic                rsv_zero;
  logic [mem_size-1:0] dec;
  logic [mem_size-1:0] set_vec;
  logic [mem_size-1:0] we_q;
  logic [reg_size-1:0] din_q;
  logic [mem_size-1:0] busy_q;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (hs),
    .gnt     (req_ready)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (req_ready[k]) begin
        sel_addr = req_addr[k];
        sel_data = req_data[k];
      end
    end
    hs      = |req_ready;
    wr_zero = ZERO_RO && (sel_addr == '0);
    dec     = '0;
    dec[sel_addr] = 1'b1;
  end

  // A register committing this cycle may be re-reserved by a younger instruction.
  always_comb begin
    rsv_zero  = ZERO_RO && (rsv_addr == '0);
    rsv_ready = rsv_zero || !busy_q[rsv_addr] || we_q[rsv_addr];
    set_vec   = '0;
    if (rsv_valid && rsv_ready && !rsv_zero) set_vec[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= '0;
      din_q  <= '0;
      busy_q <= '0;
    end else begin
      we_q <= '0;
      if (hs) begin
        din_q <= sel_data;
        if (!wr_zero) we_q <= dec;
      end
      busy_q <= (busy_q & ~we_q) | set_vec;
    end
  end

  assign rf_we  = we_q;
  assign rf_din = din_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl with a behavioural
// register file fed from rf_we/rf_din.
module tb_regfile_wb_ctrl;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0][4:0]  req_addr;
  logic [1:0][31:0] req_data;
  logic [1:0]       req_ready;
  logic [31:0]      rf_din;
  logic [31:0]      rf_we;
  logic             rsv_valid;
  logic [4:0]       rsv_addr;
  logic             rsv_ready;
  logic [31:0]      busy;

  logic [31:0] tb_mem [32];

  int n_tests;
  int n_fail;

  regfile_wb_ctrl #(
    .reg_size (32),
    .mem_size (32),
    .N_REQ    (2),
    .ZERO_RO  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_din    (rf_din),
    .rf_we     (rf_we),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (rf_we[i]) tb_mem[i] <= rf_din;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0]  rr_rdy [5];
  logic [31:0] rr_we  [5];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    rr_rdy = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    rr_we  = '{32'h0, 32'h4, 32'h2, 32'h4, 32'h2};

    #12;
    check("reset_we",   rf_we,  32'h0);
    check("reset_din",  rf_din, 32'h0);
    check("reset_busy", busy,   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write to r5 by requester 0
    drive_edge();
    req_valid   = 2'b01;
    req_addr[0] = 5'd5;
    req_data[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("single_ready", req_ready, 2'b01);
    check("single_we_idle", rf_we, 32'h0);
    drive_edge();
    req_valid = 2'b00;
    @(negedge clk);
    check("single_we",  rf_we,  32'h0000_0020);
    check("single_din", rf_din, 32'hDEAD_BEEF);
    drive_edge();
    @(negedge clk);
    check("single_we_done", rf_we, 32'h0);
    check("single_din_hold", rf_din, 32'hDEAD_BEEF);
    check("single_mem5", tb_mem[5], 32'hDEAD_BEEF);

    // Round robin: pointer sits at 1 after the requester-0 handshake above
    drive_edge();
    req_valid   = 2'b11;
    req_addr[0] = 5'd1;
    req_data[0] = 32'hA1A1_A1A1;
    req_addr[1] = 5'd2;
    req_data[1] = 32'hB2B2_B2B2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rr_ready%0d", i), req_ready, rr_rdy[i]);
      check($sformatf("rr_we%0d", i), rf_we, rr_we[i]);
      drive_edge();
      if (i == 3) req_valid = 2'b00;
    end
    check("rr_mem1", tb_mem[1], 32'hA1A1_A1A1);
    check("rr_mem2", tb_mem[2], 32'hB2B2_B2B2);

    // Scoreboard: reserve r7, blocked re-reserve, commit with same-edge reserve
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    @(negedge clk);
    check("rsv7_ready", rsv_ready, 1'b1);
    drive_edge();
    @(negedge clk);
    check("rsv7_busy", busy, 32'h80);
    check("rsv7_again_ready", rsv_ready, 1'b0);
    drive_edge();
    rsv_valid   = 1'b0;
    req_valid   = 2'b01;
    req_addr[0] = 5'd7;
    req_data[0] = 32'h7777_7777;
    @(negedge clk);
    check("w7_ready", req_ready, 2'b01);
    check("w7_busy_held", busy, 32'h80);
    drive_edge();
    req_valid = 2'b00;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    @(negedge clk);
    check("w7_commit_we", rf_we, 32'h80);
    check("w7_commit_rsv_ready", rsv_ready, 1'b1);
    drive_edge();
    rsv_valid = 1'b0;
    @(negedge clk);
    check("w7_set_wins", busy, 32'h80);
    check("w7_mem", tb_mem[7], 32'h7777_7777);
    drive_edge();
    req_valid   = 2'b01;
    req_data[0] = 32'h7070_7070;
    @(negedge clk);
    check("w7b_ready", req_ready, 2'b01);
    drive_edge();
    req_valid = 2'b00;
    @(negedge clk);
    check("w7b_we", rf_we, 32'h80);
    drive_edge();
    @(negedge clk);
    check("w7b_busy_clear", busy, 32'h0);

    // Zero register: handshake completes, no write pulse, no reservation
    drive_edge();
    req_valid   = 2'b01;
    req_addr[0] = 5'd0;
    req_data[0] = 32'hFFFF_FFFF;
    rsv_valid   = 1'b1;
    rsv_addr    = 5'd0;
    @(negedge clk);
    check("r0_ready", req_ready, 2'b01);
    check("r0_rsv_ready", rsv_ready, 1'b1);
    drive_edge();
    req_valid = 2'b00;
    rsv_valid = 1'b0;
    @(negedge clk);
    check("r0_we", rf_we, 32'h0);
    check("r0_busy", busy, 32'h0);
    check("r0_din", rf_din, 32'hFFFF_FFFF);

    // Reset mid-operation with rf_we=0x100 and busy=0x180
    drive_edge();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    drive_edge();
    rsv_addr  = 5'd8;
    drive_edge();
    rsv_valid   = 1'b0;
    req_valid   = 2'b01;
    req_addr[0] = 5'd8;
    req_data[0] = 32'h8888_8888;
    drive_edge();
    req_valid = 2'b00;
    @(negedge clk);
    check("pre_rst_we", rf_we, 32'h100);
    check("pre_rst_busy", busy, 32'h180);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_we", rf_we, 32'h0);
    check("rst_busy", busy, 32'h0);
    req_valid   = 2'b11;
    req_addr[0] = 5'd3;
    req_data[0] = 32'h3333_3333;
    req_addr[1] = 5'd4;
    req_data[1] = 32'h4444_4444;
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 2'b01);
    drive_edge();
    req_valid = 2'b00;
    @(negedge clk);
    check("post_rst_we", rf_we, 32'h8);
    check("post_rst_din", rf_din, 32'h3333_3333);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
